// File: rtl/ads1292_spi_if.sv
// SPI/DRDY link between an ADS1292 initiator (khu_sensor_top side) and the emulated target.
interface ads1292_spi_if;
  logic sclk;
  logic csn;
  logic mosi;
  logic start;
  logic miso;
  logic drdy;

  modport master (output sclk, csn, mosi, start, input miso, drdy);
  modport slave (input sclk, csn, mosi, start, output miso, drdy);
endinterface

// File: rtl/ads1292_spi_responder.sv
// ADS1292 SPI target emulation: oversampled mode-1 SPI, opcode decode, 12-byte register file
// and DRDY-paced 72-bit conversion frames.
module ads1292_spi_responder #(
  parameter int unsigned DRDY_PERIOD = 4000,
  parameter logic [7:0]  DEV_ID      = 8'h53,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  ads1292_spi_if.slave spi
);

  localparam int unsigned     CntW    = $clog2(DRDY_PERIOD);
  localparam logic [CntW-1:0] CntMax  = CntW'(DRDY_PERIOD - 1);
  localparam logic [4:0]      LastReg = 5'h0B;

  localparam logic [7:0] OpSdatac = 8'h11;
  localparam logic [7:0] OpRdatac = 8'h10;
  localparam logic [7:0] OpRdata  = 8'h12;
  localparam logic [7:0] OpStart  = 8'h08;
  localparam logic [7:0] OpStop   = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StArg,
    StRdOut,
    StWrIn,
    StFrameOut
  } state_e;

  // Input synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q, start_sync_q;
  logic sclk_prev_q, csn_prev_q;
  logic sclk_s, csn_s, mosi_s, start_s;
  logic sclk_rise, sclk_fall, csn_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      csn_sync_q   <= '1;
      mosi_sync_q  <= '0;
      start_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
      csn_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      csn_sync_q   <= {csn_sync_q[SYNC_STAGES-2:0], spi.csn};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], spi.start};
      sclk_prev_q  <= sclk_s;
      csn_prev_q   <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign start_s   = start_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~csn_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~csn_s;
  assign csn_fall  = ~csn_s & csn_prev_q;

  // Byte assembly on SCLK fall; a CSN rise throws away any partial byte
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte   = {rx_q, mosi_s};
  assign byte_done = sclk_fall && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else if (csn_s) begin
      bit_cnt_q <= '0;
    end else if (sclk_fall) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_q      <= rx_byte[6:0];
    end
  end

  // Command FSM
  state_e     state_q, state_d;
  logic       mode_q, run_q, op_wr_q;
  logic [4:0] addr_q, tx_addr;
  logic [5:0] cnt_q;
  logic       mode_set, mode_clr, run_set, run_clr, frame_load;
  logic       addr_load, cnt_load, adv, wr_en, tx_load;
  logic       is_rreg, is_wreg;

  assign is_rreg = (rx_byte[7:5] == 3'b001);
  assign is_wreg = (rx_byte[7:5] == 3'b010);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mode_set   = 1'b0;
    mode_clr   = 1'b0;
    run_set    = 1'b0;
    run_clr    = 1'b0;
    frame_load = 1'b0;
    addr_load  = 1'b0;
    cnt_load   = 1'b0;
    adv        = 1'b0;
    wr_en      = 1'b0;
    tx_load    = 1'b0;
    if (csn_s) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StCmd;
        StCmd: begin
          if (byte_done) begin
            // In continuous-read mode only SDATAC gets through
            if (rx_byte == OpSdatac) begin
              mode_clr = 1'b1;
            end else if (!mode_q) begin
              if (rx_byte == OpRdatac) begin
                mode_set = 1'b1;
              end else if (rx_byte == OpRdata) begin
                frame_load = 1'b1;
                state_d    = StFrameOut;
              end else if (rx_byte == OpStart) begin
                run_set = 1'b1;
              end else if (rx_byte == OpStop) begin
                run_clr = 1'b1;
              end else if (is_rreg || is_wreg) begin
                addr_load = 1'b1;
                state_d   = StArg;
              end
            end
          end
        end
        StArg: begin
          if (byte_done) begin
            cnt_load = 1'b1;
            tx_load  = !op_wr_q;
            state_d  = op_wr_q ? StWrIn : StRdOut;
          end
        end
        StRdOut: begin
          if (byte_done) begin
            adv     = 1'b1;
            tx_load = 1'b1;
            if (cnt_q == 6'd1) state_d = StCmd;
          end
        end
        StWrIn: begin
          if (byte_done) begin
            adv   = 1'b1;
            wr_en = 1'b1;
            if (cnt_q == 6'd1) state_d = StCmd;
          end
        end
        StFrameOut: state_d = StFrameOut;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Register file; entry 0 is the read-only ID, entries above LastReg do not exist
  logic [7:0] regs_q [16];
  logic [7:0] rd_byte;

  assign tx_addr = adv ? addr_q + 5'd1 : addr_q;

  always_comb begin
    rd_byte = 8'h00;
    if (tx_addr == 5'h00)        rd_byte = DEV_ID;
    else if (tx_addr <= LastReg) rd_byte = regs_q[tx_addr[3:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b1;
      run_q   <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      if (mode_set)      mode_q <= 1'b1;
      else if (mode_clr) mode_q <= 1'b0;
      if (run_set)       run_q <= 1'b1;
      else if (run_clr)  run_q <= 1'b0;
      if (addr_load) begin
        addr_q  <= rx_byte[4:0];
        op_wr_q <= rx_byte[6];
      end else if (adv) begin
        addr_q <= addr_q + 5'd1;
      end
      if (cnt_load) cnt_q <= 6'(rx_byte[4:0]) + 6'd1;
      else if (adv) cnt_q <= cnt_q - 6'd1;
      if (wr_en && (addr_q != 5'h00) && (addr_q <= LastReg)) regs_q[addr_q[3:0]] <= rx_byte;
    end
  end

  // Conversion pacing; the frame hold value is derived directly from the sample count
  logic [CntW-1:0] conv_cnt_q;
  logic [23:0]     sample_q;
  logic            running, tick, tick_q, drdy_q;
  logic [71:0]     frame_hold;

  assign running    = start_s | run_q;
  assign tick       = running && (conv_cnt_q == CntMax);
  assign frame_hold = {24'hC00000, sample_q, ~sample_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt_q <= '0;
      sample_q   <= '0;
      tick_q     <= 1'b0;
      drdy_q     <= 1'b1;
    end else begin
      tick_q <= tick;
      if (!running || tick) conv_cnt_q <= '0;
      else                  conv_cnt_q <= conv_cnt_q + 1'b1;
      if (tick) sample_q <= sample_q + 24'd1;
      // An unread DRDY still gets a one-cycle high pulse so the initiator sees a fresh edge
      if (tick)           drdy_q <= 1'b1;
      else if (tick_q)    drdy_q <= 1'b0;
      else if (sclk_fall) drdy_q <= 1'b1;
    end
  end

  // MISO path: register bytes in RdOut, frame stream in continuous mode or after RDATA
  logic [71:0] frame_sr_q;
  logic [7:0]  tx_sr_q;
  logic        miso_q, streaming;

  assign streaming = mode_q || (state_q == StFrameOut);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sr_q <= '0;
      tx_sr_q    <= '0;
      miso_q     <= 1'b0;
    end else begin
      if (csn_fall || frame_load)      frame_sr_q <= frame_hold;
      else if (sclk_rise && streaming) frame_sr_q <= {frame_sr_q[70:0], 1'b0};
      if (tx_load)                                 tx_sr_q <= rd_byte;
      else if (sclk_rise && (state_q == StRdOut))  tx_sr_q <= {tx_sr_q[6:0], 1'b0};
      if (csn_s) begin
        miso_q <= 1'b0;
      end else if (sclk_rise) begin
        if (state_q == StRdOut) miso_q <= tx_sr_q[7];
        else if (streaming)     miso_q <= frame_sr_q[71];
        else                    miso_q <= 1'b0;
      end
    end
  end

  assign spi.miso = miso_q;
  assign spi.drdy = drdy_q;

endmodule

// File: tb/tb_ads1292_spi_responder.sv
// Directed bench for the ADS1292 SPI target: register access, frame streaming and DRDY pacing.
module tb_ads1292_spi_responder;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   falls;

  ads1292_spi_if spi ();

  ads1292_spi_responder #(
    .DRDY_PERIOD(200),
    .DEV_ID     (8'h53),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every conversion produces exactly one DRDY falling edge, so this tracks the sample count
  always @(negedge spi.drdy or posedge rst) begin
    if (rst) falls <= 0;
    else     falls <= falls + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    spi.sclk = 1'b1;
    spi.mosi = b;
    repeat (4) @(negedge clk);
    r = spi.miso;
    spi.sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic read_frame(output logic [71:0] f, output logic drdy_first);
    logic r;
    for (int i = 71; i >= 0; i--) begin
      xfer_bit(1'b0, r);
      f[i] = r;
      if (i == 71) drdy_first = spi.drdy;
    end
  endtask

  task automatic cs_low();
    spi.csn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi.csn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drdy_fall(input string tag);
    logic prev;
    logic seen;
    prev = spi.drdy;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (prev && !spi.drdy) seen = 1'b1;
      prev = spi.drdy;
    end
    check(tag, 72'(seen), 72'd1);
  endtask

  task automatic run_len(input logic level, output int n);
    n = 0;
    while (spi.drdy === level && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [7:0]  rb;
  logic [71:0] fr;
  logic        df;
  logic        r;
  int          n;
  int          exp_s;

  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    spi.sclk = 1'b0;
    spi.csn  = 1'b1;
    spi.mosi = 1'b0;
    spi.start = 1'b0;
    do_reset();

    // Reset state and ID read
    check("rst_drdy", 72'(spi.drdy), 72'd1);
    check("rst_miso", 72'(spi.miso), 72'd0);
    cs_low(); xfer_byte(8'h11, rb); cs_high();
    check("rdatac_stream_byte0", 72'(rb), 72'hC0);
    check("miso_idle_csn_high", 72'(spi.miso), 72'd0);
    cs_low(); xfer_byte(8'h20, rb); xfer_byte(8'h00, rb); xfer_byte(8'h00, rb); cs_high();
    check("id_read", 72'(rb), 72'h53);

    // Burst write then read back; ID write dropped
    cs_low(); xfer_byte(8'h41, rb); xfer_byte(8'h01, rb);
    xfer_byte(8'hA5, rb); xfer_byte(8'h3C, rb); cs_high();
    cs_low(); xfer_byte(8'h21, rb); xfer_byte(8'h01, rb);
    xfer_byte(8'h00, rb); check("reg1", 72'(rb), 72'hA5);
    xfer_byte(8'h00, rb); check("reg2", 72'(rb), 72'h3C);
    cs_high();
    cs_low(); xfer_byte(8'h40, rb); xfer_byte(8'h00, rb); xfer_byte(8'hFF, rb); cs_high();
    cs_low(); xfer_byte(8'h20, rb); xfer_byte(8'h00, rb); xfer_byte(8'h00, rb); cs_high();
    check("id_read_only", 72'(rb), 72'h53);

    // Last register and past-end reads
    cs_low(); xfer_byte(8'h2B, rb); xfer_byte(8'h02, rb);
    xfer_byte(8'h00, rb); check("reg0b", 72'(rb), 72'h00);
    xfer_byte(8'h00, rb); check("past_end0", 72'(rb), 72'h00);
    xfer_byte(8'h00, rb); check("past_end1", 72'(rb), 72'h00);
    cs_high();

    // Partial data byte aborted by CSN rise
    cs_low(); xfer_byte(8'h41, rb); xfer_byte(8'h00, rb);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, r);
    cs_high();
    cs_low(); xfer_byte(8'h21, rb); xfer_byte(8'h00, rb); xfer_byte(8'h00, rb); cs_high();
    check("partial_write_dropped", 72'(rb), 72'hA5);

    // Write at 0x0B sticks, spill into 0x0C is dropped
    cs_low(); xfer_byte(8'h4B, rb); xfer_byte(8'h01, rb);
    xfer_byte(8'h5A, rb); xfer_byte(8'h99, rb); cs_high();
    cs_low(); xfer_byte(8'h2B, rb); xfer_byte(8'h01, rb);
    xfer_byte(8'h00, rb); check("reg0b_written", 72'(rb), 72'h5A);
    xfer_byte(8'h00, rb); check("reg0c_absent", 72'(rb), 72'h00);
    cs_high();

    // START opcode runs conversions without the pin
    cs_low(); xfer_byte(8'h08, rb); cs_high();
    wait_drdy_fall("start_opcode_drdy");
    cs_low(); xfer_byte(8'h0A, rb); cs_high();

    // Continuous mode after reset, read right after the first DRDY
    spi.start = 1'b1;
    do_reset();
    wait_drdy_fall("first_drdy");
    cs_low();
    check("drdy_low_before_read", 72'(spi.drdy), 72'd0);
    read_frame(fr, df);
    check("drdy_rise_first_sclk_fall", 72'(df), 72'd1);
    // Conversions land during this long read; it must still carry sample 1
    check("frame_sample1", fr, {24'hC00000, 24'h000001, 24'hFFFFFE});
    cs_high();
    wait_drdy_fall("next_drdy");
    exp_s = falls;
    check("conversions_during_read", 72'(exp_s >= 2), 72'd1);
    cs_low();
    read_frame(fr, df);
    check("frame_after_midread", fr, {24'hC00000, 24'(exp_s), ~24'(exp_s)});
    xfer_byte(8'h00, rb);
    check("frame_tail_zero", 72'(rb), 72'h00);
    cs_high();

    // Unread conversions: 199 cycles low, one-cycle high pulse, then the third sample
    do_reset();
    wait_drdy_fall("unread_first_drdy");
    run_len(1'b0, n); check("drdy_low_len1", 72'(n), 72'd199);
    run_len(1'b1, n); check("drdy_pulse1", 72'(n), 72'd1);
    run_len(1'b0, n); check("drdy_low_len2", 72'(n), 72'd199);
    run_len(1'b1, n); check("drdy_pulse2", 72'(n), 72'd1);
    cs_low();
    read_frame(fr, df);
    check("frame_sample3", fr, {24'hC00000, 24'h000003, 24'hFFFFFC});
    cs_high();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
